// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Used by hazard_ctrl and hazard_mc_counter.
package hazard_pkg;

    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_FLUSH = 1'b1
    } fl_state_e;

    localparam int FL_IFID = 0;
    localparam int FL_IDEX = 1;

    localparam logic DEF_STALL   = 1'b0;
    localparam logic DEF_PC_WE   = 1'b1;
    localparam logic DEF_IFID_WE = 1'b1;

endpackage

// File: rtl/hazard_mc_counter.sv
// Mult/div latency counter: loads on start, counts down, saturates at zero.
// busy_o is high while any latency cycles remain.
module hazard_mc_counter #(
    parameter int MC_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic busy_o
);
    import hazard_pkg::*;

    localparam logic [7:0] LOAD_VAL = 8'(MC_LAT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 8'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: pause, load-use, HI/LO interlock, flush sequencing.
// Optional stall-cycle counter enabled by defining HAZ_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int NUM_RD    = 2,
    parameter int FLUSH_CYC = 1,
    parameter int MC_LAT    = 32,
    parameter int FLUSH_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pause_i,
    input  logic                     jump_branch_i,
    input  logic [NUM_RD*REG_AW-1:0] id_rs_i,
    input  logic [NUM_RD-1:0]        id_rs_vld_i,
    input  logic                     id_hilo_use_i,
    input  logic [REG_AW-1:0]        ex_rd_i,
    input  logic                     ex_memrd_i,
    input  logic                     mc_start_i,
    output logic                     stall_o,
    output logic                     pc_we_o,
    output logic                     ifid_we_o,
    output logic [FLUSH_W-1:0]       flush_o,
    output logic                     mc_busy_o,
    output logic [31:0]              stall_cnt_o
);
    import hazard_pkg::*;

    localparam logic [3:0] FL_LOAD  = 4'(FLUSH_CYC - 1);
    localparam bit         FL_MULTI = (FLUSH_CYC > 1);

    fl_state_e   state_q, state_d;
    logic [3:0]  fcnt_q, fcnt_d;
    logic [NUM_RD-1:0] rs_hit;
    logic        load_use;
    logic        hilo_haz;
    logic        haz;
    logic        flush_act;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rs
        assign rs_hit[k] = id_rs_vld_i[k] &&
                           (id_rs_i[k*REG_AW +: REG_AW] == ex_rd_i);
    end

    assign load_use  = ex_memrd_i && (ex_rd_i != '0) && (|rs_hit);
    assign hilo_haz  = mc_busy_o && id_hilo_use_i;
    assign haz       = load_use || hilo_haz;
    assign flush_act = (state_q == FL_FLUSH) || jump_branch_i;

    hazard_mc_counter #(
        .MC_LAT (MC_LAT)
    ) u_mc (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (mc_start_i),
        .busy_o  (mc_busy_o)
    );

    always_comb begin
        stall_o   = DEF_STALL;
        pc_we_o   = DEF_PC_WE;
        ifid_we_o = DEF_IFID_WE;
        flush_o   = '0;
        priority case (1'b1)
            pause_i, haz: begin
                stall_o   = 1'b1;
                pc_we_o   = 1'b0;
                ifid_we_o = 1'b0;
            end
            flush_act: begin
                flush_o[FL_IFID] = 1'b1;
            end
            default: ;
        endcase
    end

    // Pause freezes the sequencer; a hazard only blocks a new redirect.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (!pause_i) begin
            if (jump_branch_i && !haz && FL_MULTI) begin
                state_d = FL_FLUSH;
                fcnt_d  = FL_LOAD;
            end else if (state_q == FL_FLUSH) begin
                if (fcnt_q <= 4'd1) begin
                    state_d = FL_IDLE;
                    fcnt_d  = 4'd0;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FL_IDLE;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else if (stall_o) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
